// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters (CPU data port, loader/DMA)
// and the arbiter, plus the arbiter's single bus toward the address decoder.
//   m0_*/m1_* : request (req/we/addr/wdata) and response (ack/err/rdata)
//   bus_*     : sequenced access to the decoder (we/addr/wdata out, rdata in)
//   busy      : arbiter not idle;  gnt_id : current bus owner
// Modports: slave = arbiter view, master = requester/decoder view.
interface mem_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_req, m0_we, m0_ack, m0_err;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
  logic                  m1_req, m1_we, m1_ack, m1_err;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata, bus_rdata;
  logic                  busy, gnt_id;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  bus_rdata,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output bus_we, bus_addr, bus_wdata, busy, gnt_id
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output bus_rdata,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  bus_we, bus_addr, bus_wdata, busy, gnt_id
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter / sequencer in front of the memory-mapped
// decoder. One access at a time: grant in IDLE, hold the bus for
// WAIT_CYCLES+1 ACCESS cycles (single write strobe in the last one), then a
// one-cycle DONE with ack (or err for an illegal address).
// Ports: clk, reset (async, active low), bus (mem_bus_arbiter_if.slave).

// Per-master response registers: ack/err pulses and the registered rdata.
module mem_bus_arbiter_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_ack,
  input  logic                  set_err,
  input  logic                  cap_rd,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= set_ack;
      err <= set_err;
      if (set_err)     rdata <= '0;
      else if (cap_rd) rdata <= bus_rdata;
    end
  end
endmodule

module mem_bus_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0] LOW_LIMIT = 32'h0040_0000
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.slave  bus
);
  localparam int          NUM_M = 2;
  localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state;
  logic                    last_gnt, gnt_r, lat_we, bus_we_r, busy_r;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   bus_addr_r;
  logic [DATA_WIDTH-1:0]   bus_wdata_r;

  logic [NUM_M-1:0]                 req_v, set_ack, set_err, cap_rd, ack_a, err_a;
  req_t [NUM_M-1:0]                 req_a;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] rdata_a;
  logic                             pick, legal, last_access;
  req_t                             sel;

  assign req_v    = {bus.m1_req, bus.m0_req};
  assign req_a[0] = {bus.m0_we, bus.m0_addr, bus.m0_wdata};
  assign req_a[1] = {bus.m1_we, bus.m1_addr, bus.m1_wdata};

  // On a tie the master that did not own the last transaction wins;
  // otherwise the lone requester (pick is don't-care when nobody asks).
  assign pick  = (&req_v) ? ~last_gnt : req_v[1];
  assign sel   = req_a[pick];
  assign legal = (sel.addr >= LOW_LIMIT) && (sel.addr[1:0] == 2'b00);

  assign last_access = (state == ACCESS) && (cnt == WC);

  // Responses are registered in the port slices: setting them on the edge
  // that enters DONE makes ack/err visible exactly during the DONE cycle.
  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign set_ack[i] = last_access && (gnt_r == 1'(i));
    assign cap_rd[i]  = set_ack[i] && !lat_we;
    assign set_err[i] = (state == IDLE) && (|req_v) && (pick == 1'(i)) && !legal;

    mem_bus_arbiter_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk       (clk),
      .reset     (reset),
      .set_ack   (set_ack[i]),
      .set_err   (set_err[i]),
      .cap_rd    (cap_rd[i]),
      .bus_rdata (bus.bus_rdata),
      .ack       (ack_a[i]),
      .err       (err_a[i]),
      .rdata     (rdata_a[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      gnt_r       <= 1'b0;
      lat_we      <= 1'b0;
      cnt         <= '0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_v) begin
          gnt_r  <= pick;
          lat_we <= sel.we;
          cnt    <= '0;
          busy_r <= 1'b1;
          if (legal) begin
            state       <= ACCESS;
            bus_addr_r  <= sel.addr;
            bus_wdata_r <= sel.wdata;
            // With zero wait states the first ACCESS cycle is the strobe cycle.
            bus_we_r    <= sel.we && (WC == 4'd0);
          end else begin
            // Illegal address: never touches the decoder bus.
            state <= DONE;
          end
        end
        ACCESS: if (cnt == WC) begin
          state    <= DONE;
          bus_we_r <= 1'b0;
        end else begin
          cnt      <= cnt + 4'd1;
          bus_we_r <= lat_we && ((cnt + 4'd1) == WC);
        end
        DONE: begin
          state       <= IDLE;
          last_gnt    <= gnt_r;
          busy_r      <= 1'b0;
          bus_addr_r  <= '0;
          bus_wdata_r <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack    = ack_a[0];
  assign bus.m0_err    = err_a[0];
  assign bus.m0_rdata  = rdata_a[0];
  assign bus.m1_ack    = ack_a[1];
  assign bus.m1_err    = err_a[1];
  assign bus.m1_rdata  = rdata_a[1];
  assign bus.bus_we    = bus_we_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.gnt_id    = gnt_r;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the memory-mapped address decoder that serves ROM, RAM, GPIO and UART.
- Master 0 is the CPU data port. Master 1 is the UART program loader / DMA writer.
- Grants one request at a time using round-robin priority and holds the bus for a fixed wait-state count.
- Returns read data with a one-cycle ack pulse; rejects illegal addresses with an error pulse.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- WAIT_CYCLES, 1, extra bus cycles per access (0..15).
- LOW_LIMIT, 32'h0040_0000, lowest legal address; addresses below it are errors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack or m0_err.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  master 0 byte address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_ack  out  1  master 0 completion pulse.
- m0_err  out  1  master 0 error pulse.
- m0_rdata  out  DATA_WIDTH  master 0 read data, registered.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0_* for master 1.
- bus_we  out  1  write strobe to the decoder's WrtEn.
- bus_addr  out  ADDR_WIDTH  address to the decoder.
- bus_wdata  out  DATA_WIDTH  write data to the selected peripheral.
- bus_rdata  in  DATA_WIDTH  read data muxed back by the decoder's Sel.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  master currently owning the bus.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; every output 0, including both rdata registers and gnt_id.
  - last_gnt=1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration at the clock edge:
  - Only one req high: grant that master.
  - Both high: grant the master that is not last_gnt.
  - On grant: latch we/addr/wdata into bus registers; gnt_id = granted master; cnt=0.
  - Legal address (addr >= LOW_LIMIT and addr[1:0]==0): go to ACCESS.
  - Otherwise: go to DONE with err_flag=1; bus_addr stays 0 and bus_we is never raised.
  - No req: remain in IDLE; bus_addr/bus_wdata/bus_we = 0.
- ACCESS:
  - Lasts WAIT_CYCLES+1 cycles; cnt counts 0..WAIT_CYCLES (4-bit counter, no wrap beyond WAIT_CYCLES).
  - bus_addr/bus_wdata held stable throughout.
  - bus_we=1 only in the cycle where cnt==WAIT_CYCLES and the latched we=1, giving exactly one write strobe per access.
  - At the edge leaving the cnt==WAIT_CYCLES cycle:
    - On a read, bus_rdata is captured into the granted master's rdata.
    - On a write, rdata is unchanged.
    - Next state is DONE.
- DONE:
  - Exactly one cycle.
  - Granted master sees ack=1, or err=1 on an error (its rdata forced to 0 on error); the other master's ack/err stay 0.
  - last_gnt = gnt_id. Next state is IDLE.
  - bus_we=0; bus_addr returns to 0 on the IDLE edge.
- Latency: grant edge to ack cycle is WAIT_CYCLES+2 cycles for a legal access and 1 cycle for an error. Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Master drops req mid-access: the access still completes and ack still pulses; no abort.
- Req changes while not granted: ignored until the next IDLE sample.
- Request of the losing master: stays pending and is served next; fairness means neither master waits more than one full transaction.
- Reset asserted mid-ACCESS: immediate return to IDLE. A write is not performed if reset falls before the strobe cycle. No ack is issued.
- addr==LOW_LIMIT is legal. addr==LOW_LIMIT-4 is an error.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Reset release, WAIT_CYCLES=1; m0 read 0x1001_0000 with bus_rdata=0xDEADBEEF -> ACCESS 2 cycles, bus_we=0, m0_ack pulses 3 cycles after the grant edge, m0_rdata=0xDEADBEEF, m1_ack=0.
- m1 write 0x1001_1024 data 0x0000_00A5 -> bus_we high exactly one cycle with bus_addr=0x1001_1024 and bus_wdata=0xA5; m1_ack pulses; m1_rdata unchanged.
- m0_req and m1_req asserted in the same cycle out of reset, held continuously -> grant order m0, m1, m0, m1; gnt_id toggles; each ack spaced 4 cycles apart.
- m0 read 0x0000_1000, then m0 read 0x1001_0002 -> m0_err pulses 1 cycle after the grant, bus_we and bus_addr stay 0, m0_rdata=0, m0_ack=0, for both.
- m1 write 0x1001_102C issued, reset pulled low during the first ACCESS cycle -> bus_we never asserted, all outputs 0 immediately; after release, m1_req still high is re-granted.
- WAIT_CYCLES=0; m0 read then m0 write back-to-back -> each access 1 ACCESS cycle, ack 2 cycles after the grant, requests accepted every 3 cycles.
